sync_edge_detector: RTL and testbench
=====================================

# sync_edge_detector

Receive-side conditioner for a single asynchronous level signal entering the `clk` domain. It resynchronizes the input through a parameterised flip-flop chain, then applies a stability filter that rejects short glitches. It produces a clean synchronized level, single-cycle rise and fall pulses, and a saturating rise-event counter. It sits directly downstream of the raw D flip-flop stage and is the point where logic in the destination domain consumes crossed signals.

## Interface

Parameters:
- `STAGES`, 2: number of synchronizer flops; legal range ≥ 2.
- `FILTER_CYCLES`, 4: consecutive synchronized cycles a new level must hold before it is accepted; legal range ≥ 1.
- `CNT_W`, 8: width of `edge_count`.

Ports:
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `async_in`, input, 1: asynchronous level from the foreign domain.
- `cnt_clr`, input, 1: synchronous clear of `edge_count` and `overflow`.
- `sync_out`, output, 1: filtered synchronized level.
- `rise_pulse`, output, 1: one-cycle pulse on each accepted 0→1 change.
- `fall_pulse`, output, 1: one-cycle pulse on each accepted 1→0 change.
- `edge_count`, output, `CNT_W`: number of accepted rising changes, saturating.
- `overflow`, output, 1: sticky flag; set when a rise occurs while `edge_count` is all-ones.

## Operation

- **Reset values:** while `rst` is high, all synchronizer flops, the filter counter, `sync_out`, `rise_pulse`, `fall_pulse`, `edge_count` and `overflow` are 0. Reset takes effect immediately and does not wait for `clk`.
- **Synchronizer:** a shift chain of `STAGES` flops. Call the last flop `s`. No logic sits between the flops.
- **Filter** uses an internal counter `fc`, sized to hold `FILTER_CYCLES-1`. On each edge:
  - If `s == sync_out`: `fc <= 0`.
  - If `s != sync_out` and `fc < FILTER_CYCLES-1`: `fc <= fc+1`.
  - If `s != sync_out` and `fc == FILTER_CYCLES-1`: `sync_out <= s` and `fc <= 0`.
- **Pulses:** `rise_pulse` and `fall_pulse` are registered and assert on the same edge that `sync_out` changes. Each is high for exactly one cycle, and both are never high together.
- **Counter:**
  - On `rise_pulse`, `edge_count` increments. It saturates at 2^`CNT_W`−1 and does not wrap.
  - A rise while saturated sets `overflow`.
  - `cnt_clr` high on an edge sets `edge_count` to 0 and clears `overflow`. If a rise occurs on the same edge, clear wins and the rise is still counted: `edge_count = 1`, `overflow = 0`.
- **Reset mid-operation:**
  - All state returns to 0 and any partially filtered change is discarded.
  - If `async_in` is held high through reset release, a full-latency rise is detected afterwards: `rise_pulse` fires and `edge_count` becomes 1.

## Timing

- **Latency:** call the first rising edge that samples a new `async_in` level edge 1. `sync_out` and the matching pulse change at edge `STAGES+FILTER_CYCLES`, provided `s` holds the new level throughout. With the defaults this is edge 6.
- **Glitch rejection:** a level change that holds in `s` for fewer than `FILTER_CYCLES` consecutive cycles produces no output change and no pulse.
- **Counter timing:** `edge_count` and `overflow` update on the edge after `rise_pulse` is high, i.e. one cycle after the pulse is visible.
- **Throughput:** maximum accepted toggle rate is one change per `FILTER_CYCLES` cycles.
- **Metastability:** only the first synchronizer flop may go metastable. Nothing downstream samples the first `STAGES-1` flops.

## Structure

- **Shared package `sync_pkg`:**
  - `SYNC_STAGES_MIN = 2`
  - `FILTER_CYCLES_MIN = 1`
  - default values for `STAGES`, `FILTER_CYCLES` and `CNT_W`
  - an elaboration-time range check on the parameters, placed in the package or at the top of the module
- **Sub-module `sync_chain`:** parameter `STAGES`; ports `clk`, `rst`, `d`, `q`. It contains only the flop chain, which keeps the synchronizer flops identifiable for CDC lint and timing constraints.
- **Top-level logic:** the filter, pulse generation and counter live in `sync_edge_detector` itself.

## Test plan

1. **Reset:** assert `rst` mid-cycle with `async_in = 1` → all outputs read 0 immediately. After release, `rise_pulse` is high for one cycle at edge 6 and `edge_count` then reads 1.
2. **Clean rise then fall (defaults):** set `async_in` 0→1 before an edge, hold 20 cycles, then 1→0 → `sync_out` rises at edge 6 with `rise_pulse` for one cycle. It falls 6 edges after the fall is first sampled, with `fall_pulse` for one cycle.
3. **Glitch:** a 1→0→1 dip lasting 3 cycles with `FILTER_CYCLES = 4` → no change on `sync_out`, no pulses. A 4-cycle dip → `fall_pulse` followed later by `rise_pulse`.
4. **Saturation:** `CNT_W = 2`, generate 5 accepted rises → `edge_count` sequence 1, 2, 3, 3, 3; `overflow` is set after the 4th rise.
5. **Clear collision:** with `edge_count = 3` and `overflow = 1`, assert `cnt_clr` on the same edge as a `rise_pulse` → `edge_count = 1`, `overflow = 0`.
6. **Parameter sweep:** `STAGES` ∈ {2, 3, 4} × `FILTER_CYCLES` ∈ {1, 4} → latency equals `STAGES+FILTER_CYCLES` edges in every case.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants for the single-bit synchronizer / edge detector.
// Holds parameter limits, defaults and a width helper used to size internal counters.
package sync_pkg;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int FILTER_CYCLES_MIN = 1;

  localparam int STAGES_DEF        = 2;
  localparam int FILTER_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 8;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Bare synchronizer flop chain; kept in its own module so CDC tools and timing
// constraints can find the synchronizer flops by hierarchy.
module sync_chain
  import sync_pkg::*;
#(
  parameter int STAGES = STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  // Only the last flop leaves the chain; earlier ones may still be settling.
  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/sync_edge_detector.sv
// Synchronizes an asynchronous level, filters out short glitches, and reports
// accepted changes as one-cycle pulses plus a saturating rise counter.
module sync_edge_detector
  import sync_pkg::*;
#(
  parameter int STAGES        = STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             async_in,
  input  logic             cnt_clr,
  output logic             sync_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow
);

  localparam int               FC_W    = cnt_width(FILTER_CYCLES);
  localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("sync_edge_detector: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end
  if (FILTER_CYCLES < FILTER_CYCLES_MIN) begin : g_bad_filter
    $error("sync_edge_detector: FILTER_CYCLES must be at least %0d", FILTER_CYCLES_MIN);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("sync_edge_detector: CNT_W must be at least 1");
  end

  logic s;

  sync_chain #(.STAGES(STAGES)) u_chain (
    .clk (clk),
    .rst (rst),
    .d   (async_in),
    .q   (s)
  );

  logic [FC_W-1:0]  fc_reg, fc_next;
  logic             sync_next, rise_next, fall_next;
  logic [CNT_W-1:0] count_next;
  logic             ovf_next;

  // fc counts consecutive cycles that s disagrees with the accepted level.
  always_comb begin
    fc_next   = fc_reg;
    sync_next = sync_out;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (s == sync_out) begin
      fc_next = '0;
    end else if (fc_reg != FC_MAX) begin
      fc_next = fc_reg + FC_W'(1);
    end else begin
      fc_next   = '0;
      sync_next = s;
      rise_next = s;
      fall_next = ~s;
    end
  end

  // The counter acts on the registered pulse; a clear still keeps a coincident rise.
  always_comb begin
    count_next = edge_count;
    ovf_next   = overflow;
    if (cnt_clr) begin
      count_next = rise_pulse ? CNT_W'(1) : '0;
      ovf_next   = 1'b0;
    end else if (rise_pulse) begin
      if (edge_count == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        count_next = edge_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_reg     <= '0;
      sync_out   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      edge_count <= '0;
      overflow   <= 1'b0;
    end else begin
      fc_reg     <= fc_next;
      sync_out   <= sync_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      edge_count <= count_next;
      overflow   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_sync_edge_detector.sv
// Directed bench for sync_edge_detector: several parameterisations share one stimulus,
// each tracked by a window-based model, plus literal checks at hand-computed edges.
module tb_sync_edge_detector;

  localparam int NI = 7;

  // Instance table: 0 defaults, 1 narrow counter, 2..6 latency sweep.
  function automatic int st_of(input int i);
    case (i)
      3, 5:    return 3;
      4, 6:    return 4;
      default: return 2;
    endcase
  endfunction
  function automatic int fc_of(input int i);
    case (i)
      2, 3, 4: return 1;
      default: return 4;
    endcase
  endfunction
  function automatic int cw_of(input int i);
    return (i == 1) ? 2 : 8;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic async_in = 1'b0;
  logic cnt_clr = 1'b0;

  always #5 clk = ~clk;

  // Packed view per instance: {sync_out, rise, fall, overflow, count[7:0]}
  logic [11:0] dut_v [NI];
  logic [11:0] exp_v [NI];

  int tests = 0;
  int fails = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int ST = st_of(gi);
    localparam int FC = fc_of(gi);
    localparam int CW = cw_of(gi);

    logic          so, rp, fp, ov;
    logic [CW-1:0] ec;

    sync_edge_detector #(.STAGES(ST), .FILTER_CYCLES(FC), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .async_in   (async_in),
      .cnt_clr    (cnt_clr),
      .sync_out   (so),
      .rise_pulse (rp),
      .fall_pulse (fp),
      .edge_count (ec),
      .overflow   (ov)
    );

    // Model: history of async_in samples since reset; the synchronized value used at
    // edge m is the sample from edge m-ST. A change is accepted when the last FC used
    // values all differ from the output and no change happened in the last FC edges.
    bit m_out, m_rise, m_fall, m_ovf;
    int m_cnt, last_chg;
    bit samp[$];

    function automatic bit s_at(input int m);
      return (m - ST >= 1) ? samp[m - ST - 1] : 1'b0;
    endfunction

    initial forever begin
      int  n;
      bit  chg;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_out = 0; m_rise = 0; m_fall = 0; m_ovf = 0;
        m_cnt = 0; last_chg = 0;
        samp.delete();
      end else begin
        if (cnt_clr) begin
          m_cnt = m_rise ? 1 : 0;
          m_ovf = 0;
        end else if (m_rise) begin
          if (m_cnt == (1 << CW) - 1) m_ovf = 1;
          else m_cnt = m_cnt + 1;
        end
        samp.push_back(async_in);
        n   = samp.size();
        chg = (n - last_chg >= FC);
        for (int m = n - FC + 1; m <= n; m++) begin
          if (s_at(m) == m_out) chg = 0;
        end
        m_rise = chg && !m_out;
        m_fall = chg && m_out;
        if (chg) begin
          m_out    = !m_out;
          last_chg = n;
        end
      end
    end

    assign dut_v[gi] = {so, rp, fp, ov, 8'(ec)};
    assign exp_v[gi] = {m_out, m_rise, m_fall, m_ovf, 8'(m_cnt)};
  end

  // Single compare process against the model, every cycle.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (dut_v[i] !== exp_v[i]) begin
        fails++;
        $display("FAIL model_cmp inst%0d t=%0t: dut=%h model=%h", i, $time, dut_v[i], exp_v[i]);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  int lat [NI];
  int lat_exp [NI] = '{6, 6, 3, 4, 5, 7, 8};
  int seq_exp [5]  = '{1, 2, 3, 3, 3};
  int nf, nr;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_state_inst0", int'(dut_v[0]), 0);

    // Clean rise; also measures per-instance latency.
    $display("[TB] rise with latency sweep");
    for (int i = 0; i < NI; i++) lat[i] = 0;
    async_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) if (lat[i] == 0 && dut_v[i][11]) lat[i] = e;
      if (e == 5) check("rise_not_before_edge6", int'(dut_v[0][10]), 0);
      if (e == 6) begin
        check("rise_pulse_edge6", int'(dut_v[0][10]), 1);
        check("sync_out_edge6", int'(dut_v[0][11]), 1);
        check("count_at_pulse", int'(dut_v[0][7:0]), 0);
      end
      if (e == 7) begin
        check("rise_pulse_one_cycle", int'(dut_v[0][10]), 0);
        check("count_after_rise", int'(dut_v[0][7:0]), 1);
      end
    end
    for (int i = 0; i < NI; i++) begin
      $display("[TB] latency inst%0d STAGES=%0d FILTER=%0d: %0d edges", i, st_of(i), fc_of(i), lat[i]);
      check($sformatf("latency_inst%0d", i), lat[i], lat_exp[i]);
    end
    repeat (8) @(negedge clk);

    $display("[TB] clean fall");
    async_in = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 5) check("fall_not_before_edge6", int'(dut_v[0][9]), 0);
      if (e == 6) check("fall_pulse_edge6", int'(dut_v[0][9]), 1);
      if (e == 7) begin
        check("fall_pulse_one_cycle", int'(dut_v[0][9]), 0);
        check("sync_out_low", int'(dut_v[0][11]), 0);
      end
    end
    repeat (6) @(negedge clk);
    async_in = 1'b1;
    repeat (12) @(negedge clk);

    $display("[TB] 3-cycle dip");
    nf = 0; nr = 0;
    async_in = 1'b0;
    repeat (3) @(negedge clk);
    async_in = 1'b1;
    repeat (12) begin
      @(negedge clk);
      nf += int'(dut_v[0][9]);
      nr += int'(dut_v[0][10]);
    end
    check("dip3_no_fall", nf, 0);
    check("dip3_no_rise", nr, 0);
    check("dip3_level_held", int'(dut_v[0][11]), 1);

    $display("[TB] 4-cycle dip");
    nf = 0; nr = 0;
    async_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nf += int'(dut_v[0][9]);
    end
    async_in = 1'b1;
    repeat (14) begin
      @(negedge clk);
      nf += int'(dut_v[0][9]);
      nr += int'(dut_v[0][10]);
    end
    check("dip4_fall", nf, 1);
    check("dip4_rise", nr, 1);

    $display("[TB] saturation with CNT_W=2");
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clear_count", int'(dut_v[1][7:0]), 0);
    for (int k = 0; k < 5; k++) begin
      async_in = 1'b0;
      repeat (8) @(negedge clk);
      async_in = 1'b1;
      repeat (8) @(negedge clk);
      $display("[TB] rise %0d: count=%0d overflow=%0d", k + 1, dut_v[1][7:0], dut_v[1][8]);
      check($sformatf("sat_count_%0d", k + 1), int'(dut_v[1][7:0]), seq_exp[k]);
      check($sformatf("sat_ovf_%0d", k + 1), int'(dut_v[1][8]), (k >= 3) ? 1 : 0);
    end

    $display("[TB] clear colliding with rise");
    async_in = 1'b0;
    repeat (8) @(negedge clk);
    async_in = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("collide_pulse", int'(dut_v[1][10]), 1);
    check("collide_pre_ovf", int'(dut_v[1][8]), 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("collide_count", int'(dut_v[1][7:0]), 1);
    check("collide_ovf", int'(dut_v[1][8]), 0);
    repeat (4) @(negedge clk);

    $display("[TB] asynchronous reset with input high");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("reset_now_inst%0d", i), int'(dut_v[i]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 5) check("post_reset_no_early_rise", int'(dut_v[0][10]), 0);
      if (e == 6) check("post_reset_rise_edge6", int'(dut_v[0][10]), 1);
      if (e == 7) check("post_reset_count", int'(dut_v[0][7:0]), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
